// File: rtl/pipe_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Record fields are sized by RA_BITS, so the controller's RA_W must equal it.
package pipe_pkg;

  localparam int RA_BITS = 5;

  typedef logic [RA_BITS-1:0] ra_t;

  localparam ra_t REG_ZERO = '0;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  // WB records reuse this type; their load bit is carried along but never read.
  typedef struct packed {
    logic valid;
    ra_t  dest;
    logic we;
    logic load;
  } stage_rec_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one in-flight stage record against one ID source register.
// Purely combinational; register 0 never matches.
module hazard_match
  import pipe_pkg::*;
(
  input  logic recValid,
  input  logic recWe,
  input  ra_t  recDest,
  input  ra_t  src,
  input  logic useSrc,
  output logic hit
);

  assign hit = recValid & recWe & useSrc & (recDest == src) & (src != REG_ZERO);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage enables, flush/bubble control and ALU forwarding for the 4-stage core.
// Outputs are combinational in the same cycle; mem_busy freezes records and counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RA_W-1:0]  id_dest,
  input  logic             id_reg_we,
  input  logic             id_mem_re,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_wb_we,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_rec_t exRec, wbRec;
  logic exHitA, exHitB, wbHitA, wbHitB;
  logic freeze, redirect, loadUse;

  hazard_match uExA (.recValid(exRec.valid), .recWe(exRec.we), .recDest(exRec.dest),
                     .src(id_rs), .useSrc(id_use_rs), .hit(exHitA));
  hazard_match uExB (.recValid(exRec.valid), .recWe(exRec.we), .recDest(exRec.dest),
                     .src(id_rt), .useSrc(id_use_rt), .hit(exHitB));
  hazard_match uWbA (.recValid(wbRec.valid), .recWe(wbRec.we), .recDest(wbRec.dest),
                     .src(id_rs), .useSrc(id_use_rs), .hit(wbHitA));
  hazard_match uWbB (.recValid(wbRec.valid), .recWe(wbRec.we), .recDest(wbRec.dest),
                     .src(id_rt), .useSrc(id_use_rt), .hit(wbHitB));

  assign freeze   = mem_busy;
  assign redirect = ex_redirect;
  assign loadUse  = id_valid & exRec.load & (exHitA | exHitB);

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_wb_we     = 1'b1;
    if (reset) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_wb_we     = 1'b0;
    end else if (freeze) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      ex_wb_we     = 1'b0;
    end else if (redirect) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (loadUse) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // A load sitting in EX has no result yet, so it never supplies the EX path.
  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (!reset) begin
      if (exHitA && !exRec.load) fwd_a_sel = FWD_EX;
      else if (wbHitA)           fwd_a_sel = FWD_WB;
      if (exHitB && !exRec.load) fwd_b_sel = FWD_EX;
      else if (wbHitB)           fwd_b_sel = FWD_WB;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      exRec     <= '0;
      wbRec     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      wbRec <= exRec;
      if (redirect || loadUse || !id_valid) begin
        exRec <= '0;
      end else begin
        exRec.valid <= 1'b1;
        exRec.dest  <= id_dest;
        exRec.we    <= id_reg_we;
        exRec.load  <= id_mem_re;
      end
      if (redirect) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (loadUse) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; narrow counters make saturation reachable quickly.
module tb_pipe_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [RA_W-1:0]  id_rs, id_rt, id_dest;
  logic             id_use_rs, id_use_rt, id_reg_we, id_mem_re;
  logic             ex_redirect, mem_busy;
  logic             pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_wb_we;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int totalCnt = 0;
  int passCnt  = 0;

  localparam logic [4:0] EN_RESET  = 5'b00110;
  localparam logic [4:0] EN_FREEZE = 5'b00000;
  localparam logic [4:0] EN_REDIR  = 5'b11111;
  localparam logic [4:0] EN_STALL  = 5'b00011;
  localparam logic [4:0] EN_NORMAL = 5'b11001;

  pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dest(id_dest), .id_reg_we(id_reg_we), .id_mem_re(id_mem_re),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_wb_we(ex_wb_we),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chkEn(input string tag, input logic [4:0] exp);
    chk(tag, {11'd0, pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_wb_we}, {11'd0, exp});
  endtask

  task automatic chkFwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk(tag, {12'd0, fwd_a_sel, fwd_b_sel}, {12'd0, a, b});
  endtask

  task automatic setId(input logic v, input int rs, input int rt, input logic urs,
                       input logic urt, input int dst, input logic we, input logic re);
    id_valid  = v;
    id_rs     = RA_W'(rs);
    id_rt     = RA_W'(rt);
    id_use_rs = urs;
    id_use_rt = urt;
    id_dest   = RA_W'(dst);
    id_reg_we = we;
    id_mem_re = re;
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    reset = 1'b1; ex_redirect = 1'b0; mem_busy = 1'b0;
    setId(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    tick(); tick();
    settle();
    chkEn("reset_enables", EN_RESET);
    chkFwd("reset_fwd", 2'b00, 2'b00);
    chk("reset_stall_cnt", 16'(stall_cnt), 16'd0);
    chk("reset_flush_cnt", 16'(flush_cnt), 16'd0);
    tick();
    reset = 1'b0;

    // add $3,$1,$2 then sub $4,$3,$5 then add $6,$5,$3
    setId(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    settle(); chkEn("add_normal", EN_NORMAL); chkFwd("add_fwd", 2'b00, 2'b00);
    tick();
    setId(1'b1, 3, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    settle(); chkEn("sub_no_stall", EN_NORMAL); chkFwd("sub_fwd_ex", 2'b01, 2'b00);
    tick();
    setId(1'b1, 5, 3, 1'b1, 1'b1, 6, 1'b1, 1'b0);
    settle(); chkFwd("add_fwd_wb_b", 2'b00, 2'b10);
    tick();

    // lw $3,0($1) then add $4,$3,$3
    setId(1'b1, 1, 3, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    settle(); chkEn("lw_normal", EN_NORMAL);
    tick();
    setId(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    settle(); chkEn("load_use_stall", EN_STALL); chkFwd("load_use_no_fwd", 2'b00, 2'b00);
    tick();
    settle();
    chk("load_use_stall_cnt", 16'(stall_cnt), 16'd1);
    chkEn("after_stall_normal", EN_NORMAL);
    chkFwd("after_stall_fwd_wb", 2'b10, 2'b10);
    tick();

    // taken branch in EX while ID holds a load-use dependent
    setId(1'b1, 1, 7, 1'b1, 1'b0, 7, 1'b1, 1'b1);
    tick();
    setId(1'b1, 7, 0, 1'b1, 1'b0, 8, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    settle(); chkEn("redirect_wins", EN_REDIR);
    tick();
    ex_redirect = 1'b0;
    setId(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    settle();
    chk("redirect_flush_cnt", 16'(flush_cnt), 16'd1);
    chk("redirect_no_stall_inc", 16'(stall_cnt), 16'd1);
    chkEn("after_redirect_normal", EN_NORMAL);
    tick();

    // writes to $0, then reads of $0
    setId(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    tick();
    setId(1'b1, 0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    settle(); chkFwd("zero_after_add", 2'b00, 2'b00);
    tick();
    setId(1'b1, 0, 0, 1'b1, 1'b1, 9, 1'b1, 1'b0);
    settle(); chkEn("zero_after_lw_no_stall", EN_NORMAL); chkFwd("zero_after_lw_fwd", 2'b00, 2'b00);
    tick();

    // mem_busy for 3 cycles over a load-use
    setId(1'b1, 1, 3, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    tick();
    setId(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle(); chkEn("freeze_enables", EN_FREEZE);
      tick();
    end
    mem_busy = 1'b0;
    settle();
    chk("freeze_no_stall_inc", 16'(stall_cnt), 16'd1);
    chkEn("post_freeze_stall", EN_STALL);
    tick();
    settle();
    chk("post_freeze_stall_cnt", 16'(stall_cnt), 16'd2);
    chkFwd("post_freeze_fwd_wb", 2'b10, 2'b10);
    tick();

    // 2^CNT_W+5 redirects saturate flush_cnt
    setId(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    ex_redirect = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
    settle();
    chk("flush_saturated", 16'(flush_cnt), 16'hF);
    chk("stall_unchanged", 16'(stall_cnt), 16'd2);
    reset = 1'b1;
    settle(); chkEn("reset_beats_redirect", EN_RESET);
    tick();
    settle();
    chk("reset_clears_flush", 16'(flush_cnt), 16'd0);
    chk("reset_clears_stall", 16'(stall_cnt), 16'd0);
    reset = 1'b0; ex_redirect = 1'b0;
    tick();

    // reset during a load-use stall clears the EX load
    setId(1'b1, 1, 3, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    tick();
    setId(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    settle(); chkEn("stall_before_reset", EN_STALL);
    reset = 1'b1;
    settle(); chkEn("reset_mid_stall", EN_RESET); chkFwd("reset_mid_stall_fwd", 2'b00, 2'b00);
    tick();
    reset = 1'b0;
    settle();
    chkEn("after_reset_no_stall", EN_NORMAL);
    chkFwd("after_reset_fwd", 2'b00, 2'b00);
    chk("after_reset_stall_cnt", 16'(stall_cnt), 16'd0);
    tick();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 4-stage MIPS core (IF, ID, EX, WB), sitting beside the controller, register file, ALU and data memory.
- Tracks the destination register of each in-flight instruction in EX and WB.
- Produces stage-register enables, flushes and bubble insertion, plus ALU operand forwarding selects.
- Freezes the whole pipe while the data memory/serial port is busy.
- Keeps saturating stall/flush event counters for debug.

## Interface
Parameters:
- RA_W, 5, register address width
- CNT_W, 16, event counter width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  RA_W each  ID source registers
- id_use_rs, id_use_rt  in  1 each  instruction reads rs / rt
- id_dest  in  RA_W  ID destination (after RegDst mux)
- id_reg_we  in  1  ID instruction writes a register
- id_mem_re  in  1  ID instruction is a load
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle
- mem_busy  in  1  data memory cannot complete EX access this cycle
- pc_we  out  1  PC register enable
- if_id_we  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_bubble  out  1  ID/EX loads a NOP
- ex_wb_we  out  1  EX/WB register enable
- fwd_a_sel, fwd_b_sel  out  2 each  ALU operand source: 00 regfile, 01 EX result, 10 WB write data
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
Internal records:
- ex_rec = {valid, dest, we, load}
- wb_rec = {valid, dest, we}

Matching rule:
- A record "hits" source r when valid & we & dest==r & r!=0 & the matching id_use_* is set.
- Register 0 never hits.

Conditions, evaluated combinationally every cycle:
- freeze = mem_busy.
- load_use = id_valid & ex_rec.load & (hit on rs or rt).
- Precedence: reset > freeze > redirect > load_use > normal.

Per condition (pc_we / if_id_we / if_id_flush / id_ex_bubble / ex_wb_we):
- reset: 0/0/1/1/0.
- freeze: 0/0/0/0/0; records hold.
- redirect: 1/1/1/1/1; ID instruction killed.
- load_use: 0/0/0/1/1; one bubble.
- normal: 1/1/0/0/1.

Record update on clock edge when not freeze:
- wb_rec <= ex_rec.
- ex_rec <= invalid if (redirect | load_use | !id_valid); otherwise {1, id_dest, id_reg_we, id_mem_re}.

Forwarding, per operand (rs → a, rt → b):
- EX hit on a non-load record → 01.
- Otherwise WB hit → 10.
- Otherwise 00.
- EX takes priority over WB.
- A load in EX never forwards; it stalls instead.

Counters:
- stall_cnt increments on each load_use cycle that is not frozen or redirected.
- flush_cnt increments on each redirect cycle that is not frozen.
- Both saturate at all-ones and do not wrap.

## Timing
- Enables and selects are combinational from current records and inputs, valid in the same cycle. There is no added latency.
- Records and counters update on posedge clock.
- Reset values: records invalid, counters 0, fwd selects 00. Output enables take the reset row.
- Load-use costs exactly 1 cycle.
  - Next cycle: the load is in WB, ex_rec is the bubble, and the dependent instruction gets fwd 10.
- Redirect kills exactly the IF and ID instructions.
  - The EX instruction completes normally.
- Simultaneous redirect and load_use: redirect wins, no stall, flush_cnt increments only.
- mem_busy held N cycles stretches any condition by N cycles with no state change. This includes an in-progress load_use.
- Reset mid-stall or mid-freeze clears everything on the next edge.

## Structure
- Shared package pipe_pkg holds:
  - fwd encodings FWD_RF=2'b00, FWD_EX=2'b01, FWD_WB=2'b10.
  - REG_ZERO.
  - stage_rec_t typedef.
- Sub-module hazard_match (record vs. source hit compare, instantiated 4×) is natural.
- Counters stay inline.

## Test plan
- Back-to-back add $3,$1,$2 then sub $4,$3,$5 → fwd_a_sel=01, no stall.
- lw $3 then add $4,$3,$3 → 1 cycle with pc_we=0, id_ex_bubble=1, stall_cnt=1. The next cycle has fwd_a_sel=fwd_b_sel=10.
- Taken beq in EX while ID holds a load-use dependent → if_id_flush=1, id_ex_bubble=1, pc_we=1, flush_cnt=1, stall_cnt=0.
- Writes to $0 followed by reads of $0 → fwd selects remain 00, no stall.
- mem_busy held 3 cycles during a load_use → all enables 0 for 3 cycles, then the normal 1-cycle stall; stall_cnt increments once.
- 2^CNT_W+5 redirects → flush_cnt holds at all-ones; reset mid-sequence returns counters to 0 and enables to the reset row.
